// File: rtl/mole_round_scheduler_if.sv
// Purpose: game-control bundle between the sequencer and the start/hammer/display logic.
// Latency: wiring only; every sequencer output is driven straight from registered state.
// Backpressure: none; hit and start are sampled every cycle, new_mole is a one-cycle trigger.
interface mole_round_scheduler_if;
    logic        start;
    logic [3:0]  difficulty;
    logic        hit;
    logic        new_mole;
    logic        mole_active;
    logic        countdown_active;
    logic [11:0] countdown_ms;
    logic [11:0] score;
    logic [7:0]  mole_index;
    logic [3:0]  misses;
    logic        game_over;
    logic [2:0]  state;

    // Game-side driver: start/difficulty/hit sources, observes game status.
    modport master (
        output start, difficulty, hit,
        input  new_mole, mole_active, countdown_active, countdown_ms,
        input  score, mole_index, misses, game_over, state
    );

    // Sequencer side.
    modport slave (
        input  start, difficulty, hit,
        output new_mole, mole_active, countdown_active, countdown_ms,
        output score, mole_index, misses, game_over, state
    );
endinterface

// File: rtl/mole_round_scheduler.sv
// Purpose: whack-a-mole game sequencer (countdown, mole spawn/window, scoring, game over).
// Latency: start edge -> COUNTDOWN next cycle; hit/expiry -> exit ACTIVE on the following edge.
// Backpressure: none; MOLE_SPEEDUP_EN shrinks the live mole window by 50 ms per hit (floor 300 ms).
module mole_round_scheduler #(
    parameter int CLKS_PER_MS  = 50000,
    parameter int COUNTDOWN_MS = 3000,
    parameter int GAP_MS       = 500,
    parameter int EASY_MS      = 2000,
    parameter int MEDIUM_MS    = 1500,
    parameter int HARD_MS      = 1000,
    parameter int NUM_MOLES    = 20,
    parameter int MAX_MISSES   = 5,
    parameter int POINTS       = 50
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mole_round_scheduler_if.slave  bus
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_COUNTDOWN = 3'd1;
    localparam logic [2:0] S_SPAWN     = 3'd2;
    localparam logic [2:0] S_ACTIVE    = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;
    localparam logic [2:0] S_GAMEOVER  = 3'd5;

    logic [2:0]  state_q, state_d;
    logic        start_q;
    logic [15:0] presc_q, presc_d;
    logic [15:0] ms_q, ms_d;
    logic [11:0] cd_q, cd_d;
    logic [11:0] score_q, score_d;
    logic [7:0]  idx_q, idx_d;
    logic [3:0]  miss_q, miss_d;
    logic [15:0] win_q, win_d;

    logic        start_rise;
    logic        tick;
    logic        win_done;
    logic        gap_done;
    logic [12:0] score_sum;
    logic [15:0] diff_win;

    assign start_rise = bus.start & ~start_q;
    assign tick       = (presc_q == 16'(CLKS_PER_MS - 1));
    assign win_done   = tick && (ms_q == win_q - 16'd1);
    assign gap_done   = tick && (ms_q == 16'(GAP_MS - 1));
    assign score_sum  = {1'b0, score_q} + 13'(POINTS);

    // Difficulty code to window length; unknown codes fall back to easy.
    always_comb begin
        case (bus.difficulty)
            4'd1:    diff_win = 16'(MEDIUM_MS);
            4'd2:    diff_win = 16'(HARD_MS);
            default: diff_win = 16'(EASY_MS);
        endcase
    end

    // Next-state and game counters.
    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        score_d = score_q;
        idx_d   = idx_q;
        miss_d  = miss_q;
        win_d   = win_q;
        case (state_q)
            S_IDLE, S_GAMEOVER: begin
                if (start_rise) begin
                    win_d   = diff_win;
                    score_d = 12'd0;
                    idx_d   = 8'd0;
                    miss_d  = 4'd0;
                    cd_d    = 12'(COUNTDOWN_MS);
                    state_d = S_COUNTDOWN;
                end
            end
            S_COUNTDOWN: begin
                if (tick) begin
                    if (cd_q != 12'd0) cd_d = cd_q - 12'd1;
                    if (cd_q <= 12'd1) state_d = S_SPAWN;
                end
            end
            S_SPAWN: begin
                idx_d   = idx_q + 8'd1;
                state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                // A hit on the expiry cycle takes priority, so no miss is booked.
                if (bus.hit || win_done) begin
                    if (bus.hit) begin
                        score_d = score_sum[12] ? 12'hFFF : score_sum[11:0];
`ifdef MOLE_SPEEDUP_EN
                        win_d = (win_q >= 16'd350) ? (win_q - 16'd50) : 16'd300;
`endif
                    end else begin
                        miss_d = miss_q + 4'd1;
                    end
                    if (idx_q == 8'(NUM_MOLES) || miss_d == 4'(MAX_MISSES))
                        state_d = S_GAMEOVER;
                    else
                        state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_done) state_d = S_SPAWN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ms timebase restarts on every state change so each state is timed from its entry.
    always_comb begin
        presc_d = presc_q + 16'd1;
        ms_d    = ms_q;
        if (state_d != state_q) begin
            presc_d = 16'd0;
            ms_d    = 16'd0;
        end else if (tick) begin
            presc_d = 16'd0;
            ms_d    = ms_q + 16'd1;
        end
    end

    // State, timer and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            presc_q <= 16'd0;
            ms_q    <= 16'd0;
            cd_q    <= 12'(COUNTDOWN_MS);
            score_q <= 12'd0;
            idx_q   <= 8'd0;
            miss_q  <= 4'd0;
            win_q   <= 16'(EASY_MS);
        end else begin
            state_q <= state_d;
            start_q <= bus.start;
            presc_q <= presc_d;
            ms_q    <= ms_d;
            cd_q    <= cd_d;
            score_q <= score_d;
            idx_q   <= idx_d;
            miss_q  <= miss_d;
            win_q   <= win_d;
        end
    end

    assign bus.new_mole         = (state_q == S_SPAWN);
    assign bus.mole_active      = (state_q == S_ACTIVE);
    assign bus.countdown_active = (state_q == S_COUNTDOWN);
    assign bus.game_over        = (state_q == S_GAMEOVER);
    assign bus.countdown_ms     = cd_q;
    assign bus.score            = score_q;
    assign bus.mole_index       = idx_q;
    assign bus.misses           = miss_q;
    assign bus.state            = state_q;

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Purpose: directed checks of the mole sequencer with a 4-cycle ms tick.
// Latency: inputs driven 1 time unit after posedge, outputs sampled at the same point.
// Backpressure: not applicable.
module tb_mole_round_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cnt;
    int   nm;
    logic [31:0] ms4;
    logic [31:0] mslast;

    mole_round_scheduler_if bus ();

    mole_round_scheduler #(
        .CLKS_PER_MS(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.difficulty = 4'd2;
        bus.hit        = 1'b0;

        // Reset values
        #12;
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_cd_ms", 32'(bus.countdown_ms), 3000);
        chk("rst_score", 32'(bus.score), 0);
        chk("rst_go", 32'(bus.game_over), 0);
        rst_n = 1'b1;
        step(2);
        chk("idle_state", 32'(bus.state), 0);

        // Game 1: countdown
        bus.start = 1'b1;
        step(1);
        chk("cd_enter_state", 32'(bus.state), 1);
        chk("cd_enter_ms", 32'(bus.countdown_ms), 3000);
        cnt = 0;
        ms4 = '0;
        mslast = '0;
        while (bus.countdown_active && cnt < 20000) begin
            if (cnt == 4) ms4 = 32'(bus.countdown_ms);
            mslast = 32'(bus.countdown_ms);
            if (cnt == 100) bus.start = 1'b0;
            if (cnt == 102) bus.start = 1'b1;
            cnt++;
            step(1);
        end
        chk("cd_len", cnt, 12000);
        chk("cd_ms_after_1tick", ms4, 2999);
        chk("cd_ms_last", mslast, 1);
        chk("cd_ms_zero", 32'(bus.countdown_ms), 0);
        chk("spawn1_pulse", 32'(bus.new_mole), 1);
        chk("spawn1_idx_before", 32'(bus.mole_index), 0);
        step(1);
        chk("spawn1_pulse_len", 32'(bus.new_mole), 0);
        chk("spawn1_idx", 32'(bus.mole_index), 1);

        // Mole 1: no hit
        cnt = 0;
        while (bus.mole_active && cnt < 10000) begin
            cnt++;
            step(1);
        end
        chk("win1_len", cnt, 4000);
        chk("win1_misses", 32'(bus.misses), 1);
        chk("win1_score", 32'(bus.score), 0);
        chk("win1_to_gap", 32'(bus.state), 4);
        cnt = 0;
        while (bus.state == 3'd4 && cnt < 10000) begin
            cnt++;
            step(1);
        end
        chk("gap1_len", cnt, 2000);
        chk("spawn2_pulse", 32'(bus.new_mole), 1);

        // Mole 2: hit 10 cycles in, then a stray hit in GAP
        step(1);
        chk("spawn2_idx", 32'(bus.mole_index), 2);
        step(10);
        bus.hit = 1'b1;
        step(1);
        bus.hit = 1'b0;
        chk("hit2_score", 32'(bus.score), 50);
        chk("hit2_drop", 32'(bus.mole_active), 0);
        chk("hit2_misses", 32'(bus.misses), 1);
        step(5);
        bus.hit = 1'b1;
        step(1);
        bus.hit = 1'b0;
        chk("gap_hit_ignored", 32'(bus.score), 50);
        cnt = 0;
        while (!bus.new_mole && cnt < 10000) begin
            cnt++;
            step(1);
        end
        chk("spawn3_pulse", 32'(bus.new_mole), 1);

        // Mole 3: hit on the expiry cycle
        step(1);
        step(3999);
        chk("win3_still_open", 32'(bus.mole_active), 1);
        bus.hit = 1'b1;
        step(1);
        bus.hit = 1'b0;
        chk("exp_hit_score", 32'(bus.score), 100);
        chk("exp_hit_misses", 32'(bus.misses), 1);
        chk("exp_hit_state", 32'(bus.state), 4);

        // Mole 4: asynchronous reset mid-window
        cnt = 0;
        while (!bus.new_mole && cnt < 10000) begin
            cnt++;
            step(1);
        end
        step(21);
        chk("win4_open", 32'(bus.mole_active), 1);
        #2;
        rst_n = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("arst_state", 32'(bus.state), 0);
        chk("arst_active", 32'(bus.mole_active), 0);
        chk("arst_score", 32'(bus.score), 0);
        chk("arst_idx", 32'(bus.mole_index), 0);
        chk("arst_misses", 32'(bus.misses), 0);
        chk("arst_cd_ms", 32'(bus.countdown_ms), 3000);
        step(2);
        rst_n = 1'b1;
        nm = 0;
        repeat (50) begin
            if (bus.new_mole || bus.state != 3'd0) nm++;
            step(1);
        end
        chk("post_rst_quiet", nm, 0);

        // Game 2: five misses end the game; mid-game difficulty change ignored
        bus.difficulty = 4'd2;
        bus.start = 1'b1;
        step(1);
        chk("g2_state", 32'(bus.state), 1);
        bus.difficulty = 4'd0;
        cnt = 0;
        while (!bus.game_over && cnt < 60000) begin
            cnt++;
            step(1);
        end
        chk("g2_len", cnt, 40005);
        chk("g2_misses", 32'(bus.misses), 5);
        chk("g2_idx", 32'(bus.mole_index), 5);
        chk("g2_state_go", 32'(bus.state), 5);
        chk("g2_active", 32'(bus.mole_active), 0);
        bus.hit = 1'b1;
        step(1);
        bus.hit = 1'b0;
        chk("go_hit_ignored", 32'(bus.score), 0);
        chk("go_hold", 32'(bus.state), 5);

        // Restart from GAMEOVER
        bus.start = 1'b0;
        step(2);
        bus.start = 1'b1;
        step(1);
        chk("rs_state", 32'(bus.state), 1);
        chk("rs_misses", 32'(bus.misses), 0);
        chk("rs_idx", 32'(bus.mole_index), 0);
        chk("rs_cd_ms", 32'(bus.countdown_ms), 3000);
        chk("rs_go", 32'(bus.game_over), 0);
        chk("rs_cd_active", 32'(bus.countdown_active), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
